// File: rtl/button_debouncer_re_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default timing constants and a small state-classification helper.
package button_debouncer_re_pkg;

    // Debouncer FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } db_state_e;

    // Default timing for a 50 MHz system clock; also used by the LED driver top level
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms
    localparam int DEF_CNT_WIDTH       = 25;

    // True while the debounced button is considered held (auto-repeat may count)
    function automatic logic is_held(db_state_e st);
        return (st == S_HIGH) || (st == S_FALL_WAIT);
    endfunction

endpackage

// File: rtl/button_debouncer_re_if.sv
// Button conditioning bus: raw input and repeat enable towards the debouncer,
// clean level and single-cycle strobes back towards the consumer.
interface button_debouncer_re_if;
    logic btn_raw;
    logic repeat_en;
    logic btn_level;
    logic btn_re;
    logic btn_fe;
    logic btn_pulse;

    modport master (
        output btn_raw,
        output repeat_en,
        input  btn_level,
        input  btn_re,
        input  btn_fe,
        input  btn_pulse
    );

    modport slave (
        input  btn_raw,
        input  repeat_en,
        output btn_level,
        output btn_re,
        output btn_fe,
        output btn_pulse
    );
endinterface

// File: rtl/button_debouncer_re_sync.sv
// Generic multi-flop synchroniser for a single asynchronous bit.
// Reusable for any other asynchronous input; clears to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer_re.sv
// Push-button conditioner: synchronises the raw button, debounces it with a
// four-state FSM, and produces registered edge strobes plus an optional
// auto-repeat pulse train while the button is held.
module button_debouncer_re
    import button_debouncer_re_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    button_debouncer_re_if.slave   bus
);

    // A single stable sample is enough: skip the wait states entirely
    localparam bit DB_BYPASS = (DEBOUNCE_CYCLES == 32'sd1);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE         = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] DB_LAST         = CNT_WIDTH'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] REP_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] REP_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 32'sd1);

    logic                 w_s;

    db_state_e            r_state;
    logic [CNT_WIDTH-1:0] r_db_cnt;
    logic [CNT_WIDTH-1:0] r_rep_cnt;
    logic                 r_rep_first;
    logic                 r_level;
    logic                 r_re;
    logic                 r_fe;
    logic                 r_pulse;

    db_state_e            w_state_nxt;
    logic [CNT_WIDTH-1:0] w_db_cnt_nxt;
    logic                 w_level_nxt;
    logic                 w_re_nxt;
    logic                 w_fe_nxt;

    logic [CNT_WIDTH-1:0] w_rep_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_rep_lim;
    logic                 w_rep_first_nxt;
    logic                 w_tick;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .sync_reset (sync_reset),
        .i_d        (bus.btn_raw),
        .o_q        (w_s)
    );

    // Debounce FSM: next state, debounce counter, level and edge strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_level_nxt  = r_level;
        w_re_nxt     = 1'b0;
        w_fe_nxt     = 1'b0;

        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    if (DB_BYPASS) begin
                        w_state_nxt  = S_HIGH;
                        w_db_cnt_nxt = '0;
                        w_level_nxt  = 1'b1;
                        w_re_nxt     = 1'b1;
                    end else begin
                        w_state_nxt  = S_RISE_WAIT;
                        w_db_cnt_nxt = CNT_ONE;
                    end
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end
            S_RISE_WAIT: begin
                if (!w_s) begin
                    // Glitch: input fell back before becoming stable
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = '0;
                    w_level_nxt  = 1'b1;
                    w_re_nxt     = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    if (DB_BYPASS) begin
                        w_state_nxt  = S_LOW;
                        w_db_cnt_nxt = '0;
                        w_level_nxt  = 1'b0;
                        w_fe_nxt     = 1'b1;
                    end else begin
                        w_state_nxt  = S_FALL_WAIT;
                        w_db_cnt_nxt = CNT_ONE;
                    end
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end
            S_FALL_WAIT: begin
                if (w_s) begin
                    // Bounce back high: release not yet accepted
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = '0;
                    w_level_nxt  = 1'b0;
                    w_fe_nxt     = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt  = S_LOW;
                w_db_cnt_nxt = '0;
                w_level_nxt  = 1'b0;
            end
        endcase
    end

    // Auto-repeat: counts only while held before and after this edge, so it
    // is idle on the press edge and can never tick on the release edge
    always_comb begin
        w_rep_cnt_nxt   = '0;
        w_rep_first_nxt = 1'b1;
        w_tick          = 1'b0;
        w_rep_lim       = r_rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST;

        if (bus.repeat_en && is_held(r_state) && is_held(w_state_nxt)) begin
            if (r_rep_cnt == w_rep_lim) begin
                w_tick          = 1'b1;
                w_rep_cnt_nxt   = '0;
                w_rep_first_nxt = 1'b0;
            end else begin
                w_rep_cnt_nxt   = r_rep_cnt + CNT_ONE;
                w_rep_first_nxt = r_rep_first;
            end
        end else begin
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b1;
        end
    end

    // State, counters and registered outputs; reset dominates everything
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state     <= S_LOW;
            r_db_cnt    <= '0;
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
            r_level     <= 1'b0;
            r_re        <= 1'b0;
            r_fe        <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_first <= w_rep_first_nxt;
            r_level     <= w_level_nxt;
            r_re        <= w_re_nxt;
            r_fe        <= w_fe_nxt;
            r_pulse     <= w_re_nxt | w_tick;
        end
    end

    assign bus.btn_level = r_level;
    assign bus.btn_re    = r_re;
    assign bus.btn_fe    = r_fe;
    assign bus.btn_pulse = r_pulse;

endmodule

// File: tb/tb_button_debouncer_re.sv
// Bench for button_debouncer_re. Directed stimulus pushes hand-computed strobe
// events {edge, re, fe, pulse} into a queue; a monitor pops one event whenever
// any strobe is high and compares it. A bounce soak uses a run-length model.
module tb_button_debouncer_re;

    typedef struct packed {
        int   edge_n;
        logic re;
        logic fe;
        logic pulse;
    } ev_t;

    logic clk = 1'b0;
    logic sync_reset;
    button_debouncer_re_if bus();

    button_debouncer_re #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .CNT_WIDTH       (8)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    int   cyc   = 0;      // number of rising edges so far
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_re  = 0;
    int   n_fe  = 0;
    ev_t  exp_q[$];
    bit   soak_on = 1'b0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    logic lvl_m = 1'b0;
    int   run_m = 0;

    always #5 clk = ~clk;

    function automatic ev_t mk_ev(int e, logic re, logic fe, logic pulse);
        ev_t ev;
        ev.edge_n = e;
        ev.re     = re;
        ev.fe     = fe;
        ev.pulse  = pulse;
        return ev;
    endfunction

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(int e, logic re, logic fe, logic pulse);
        exp_q.push_back(mk_ev(e, re, fe, pulse));
    endtask

    // Return 1 ns after edge n-1, so what is driven next is sampled at edge n
    task automatic goto(int n);
        while (cyc < n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge counter plus soak model: level flips on the 4th consecutive
    // edge whose two-edge-delayed raw sample disagrees with the level
    always @(posedge clk) begin
        cyc <= cyc + 1;
        h1  <= bus.btn_raw;
        h2  <= h1;
        if (soak_on) begin
            if (h2 != lvl_m) begin
                if (run_m == 3) begin
                    lvl_m <= ~lvl_m;
                    run_m <= 0;
                    exp_q.push_back(mk_ev(cyc + 1, ~lvl_m, lvl_m, ~lvl_m));
                end else begin
                    run_m <= run_m + 1;
                end
            end else begin
                run_m <= 0;
            end
        end
    end

    // Monitor: pop and compare an expected event whenever a strobe shows
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (soak_on) check("soak_level", int'(bus.btn_level), int'(lvl_m));
            if (bus.btn_re)  n_re++;
            if (bus.btn_fe)  n_fe++;
            if (bus.btn_re || bus.btn_fe || bus.btn_pulse) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_strobe at edge %0d: got re/fe/pulse=%b%b%b, expected none",
                             cyc, bus.btn_re, bus.btn_fe, bus.btn_pulse);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_edge", cyc, e.edge_n);
                    check("strobe_bits", int'({bus.btn_re, bus.btn_fe, bus.btn_pulse}),
                          int'({e.re, e.fe, e.pulse}));
                end
            end
        end
    end

    task automatic check_all_zero(string name);
        check(name, int'({bus.btn_level, bus.btn_re, bus.btn_fe, bus.btn_pulse}), 0);
    endtask

    initial begin
        sync_reset    = 1'b1;
        bus.btn_raw   = 1'b0;
        bus.repeat_en = 1'b0;

        // Reset held over edges 1..3
        goto(4);
        check_all_zero("reset_state");
        sync_reset = 1'b0;

        // Clean press sampled at edge 10 -> rise at 15, release at 30 -> fall at 35
        goto(10); bus.btn_raw = 1'b1; push(15, 1'b1, 1'b0, 1'b1);
        goto(16); check("press_level", int'(bus.btn_level), 1);
        goto(17); check("re_one_cycle", int'(bus.btn_re), 0);
        goto(30); bus.btn_raw = 1'b0; push(35, 1'b0, 1'b1, 1'b0);
        goto(37); check("release_level", int'(bus.btn_level), 0);

        // Glitch: 3 high samples rejected; 4 high samples accepted
        goto(40); bus.btn_raw = 1'b1;
        goto(43); bus.btn_raw = 1'b0;
        goto(48); check("glitch_level", int'(bus.btn_level), 0);
        goto(50); bus.btn_raw = 1'b1; push(55, 1'b1, 1'b0, 1'b1);
        goto(54); bus.btn_raw = 1'b0; push(59, 1'b0, 1'b1, 1'b0);

        // Bouncy release: one fall, 5 edges after the last 1->0
        goto(70); bus.btn_raw = 1'b1; push(75, 1'b1, 1'b0, 1'b1);
        goto(90); bus.btn_raw = 1'b0;
        goto(91); bus.btn_raw = 1'b1;
        goto(92); bus.btn_raw = 1'b0;
        goto(93); bus.btn_raw = 1'b1;
        goto(94); bus.btn_raw = 1'b0; push(99, 1'b0, 1'b1, 1'b0);

        // Auto-repeat through release; last tick lands during the fall wait
        goto(100); bus.repeat_en = 1'b1;
        goto(110); bus.btn_raw = 1'b1;
        push(115, 1'b1, 1'b0, 1'b1);
        push(125, 1'b0, 1'b0, 1'b1);
        push(128, 1'b0, 1'b0, 1'b1);
        push(131, 1'b0, 1'b0, 1'b1);
        push(134, 1'b0, 1'b0, 1'b1);
        goto(136); bus.btn_raw = 1'b0;
        push(137, 1'b0, 1'b0, 1'b1);
        push(140, 1'b0, 1'b0, 1'b1);
        push(141, 1'b0, 1'b1, 1'b0);

        // repeat_en dropped on the edge a tick was due: no tick
        goto(150); bus.btn_raw = 1'b1;
        push(155, 1'b1, 1'b0, 1'b1);
        push(165, 1'b0, 1'b0, 1'b1);
        push(168, 1'b0, 1'b0, 1'b1);
        goto(171); bus.repeat_en = 1'b0;
        goto(180); bus.btn_raw = 1'b0; push(185, 1'b0, 1'b1, 1'b0);

        // Reset during rise wait; held button needs the full latency again
        goto(200); bus.btn_raw = 1'b1;
        goto(204); sync_reset = 1'b1;
        goto(205); sync_reset = 1'b0;
        check_all_zero("reset_rise_wait");
        push(210, 1'b1, 1'b0, 1'b1);
        goto(215); bus.btn_raw = 1'b0; push(220, 1'b0, 1'b1, 1'b0);

        // Reset during auto-repeat, then a tick suppressed on the release edge
        goto(225); bus.repeat_en = 1'b1;
        goto(230); bus.btn_raw = 1'b1;
        push(235, 1'b1, 1'b0, 1'b1);
        push(245, 1'b0, 1'b0, 1'b1);
        push(248, 1'b0, 1'b0, 1'b1);
        goto(250); sync_reset = 1'b1;
        goto(251); sync_reset = 1'b0;
        check_all_zero("reset_repeat");
        push(256, 1'b1, 1'b0, 1'b1);
        push(266, 1'b0, 1'b0, 1'b1);
        push(269, 1'b0, 1'b0, 1'b1);
        goto(270); bus.btn_raw = 1'b0;
        push(272, 1'b0, 1'b0, 1'b1);
        push(275, 1'b0, 1'b1, 1'b0);
        goto(280); bus.repeat_en = 1'b0;
        goto(290); check("queue_drained_directed", exp_q.size(), 0);

        // Random bounce soak
        goto(300);
        n_re    = 0;
        n_fe    = 0;
        soak_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.btn_raw = 1'($urandom_range(0, 1));
            goto(cyc + 1 + int'($urandom_range(1, 7)));
        end
        bus.btn_raw = 1'b0;
        goto(cyc + 20);
        soak_on = 1'b0;
        check("soak_final_level", int'(bus.btn_level), 0);
        check("soak_re_fe_balance", int'((n_re - n_fe <= 1) && (n_fe - n_re <= 1)), 1);
        check("queue_drained_soak", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
